// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add sequencer: FSM state encoding and counter sizing.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter must be able to hold W itself (value after the last capture).
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_shreg.sv
// Purpose: W-bit right-shift register, parallel load, serial-in at MSB.
// Latency: load/shift visible one cycle after the enabling edge.
// Backpressure: none; load has priority over shift, otherwise holds.
module serial_add_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_dat;
        end else if (shift) begin
            sh_d = {sin, sh_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q = sh_q;

endmodule

// File: rtl/serial_add_seq.sv
// Purpose: feeds an external 1-bit full adder LSB-first and assembles the W-bit sum.
// Latency: out_valid rises W*(FA_LAT+1) cycles after the accept edge.
// Backpressure: one op in flight; result and in_ready=0 held until out_ready.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W      = 4,
    parameter int FA_LAT = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    output logic         fa_issue,
    input  logic         fa_sum,
    input  logic         fa_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int CW = cnt_w(W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_sum_q, out_sum_d;
    logic           out_cout_q, out_cout_d;
    logic           out_ovf_q, out_ovf_d;

    logic           accept;
    logic           capture;
    logic           last;
    logic [W-1:0]   a_q, b_q, r_q;

    assign accept = in_valid & in_ready_q;
    assign last   = (cnt_q == CW'(W - 1));

    // With a combinational adder the sum is taken in the issue cycle itself.
    assign capture = (FA_LAT == 0) ? (state_q == ST_ISSUE) : (state_q == ST_WAIT);

    serial_add_shreg #(.W(W)) u_a_sh (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept),
        .load_dat (in_a),
        .shift    (capture),
        .sin      (1'b0),
        .q        (a_q)
    );

    serial_add_shreg #(.W(W)) u_b_sh (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept),
        .load_dat (in_b),
        .shift    (capture),
        .sin      (1'b0),
        .q        (b_q)
    );

    serial_add_shreg #(.W(W)) u_r_sh (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept),
        .load_dat ('0),
        .shift    (capture),
        .sin      (fa_sum),
        .q        (r_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                    carry_d = in_cin;
                end
            end
            ST_ISSUE: begin
                if (FA_LAT == 0) begin
                    state_d = last ? ST_DONE : ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
                // Result is published separately so it survives the next operation's shifting.
                out_sum_d  = {fa_sum, r_q[W-1:1]};
                out_cout_d = fa_cout;
                out_ovf_d  = fa_cout ^ carry_q;
            end
        end
    end

    assign in_ready_d  = (state_d == ST_IDLE);
    assign out_valid_d = (state_d == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Operand bits are only consumed at bit 0 as they shift past.
    logic unused_bits;
    assign unused_bits = ^{a_q[W-1:1], b_q[W-1:1], r_q[0]};

    assign fa_a      = a_q[0];
    assign fa_b      = b_q[0];
    assign fa_cin    = carry_q;
    assign fa_issue  = (state_q == ST_ISSUE);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench: one sequencer with a registered full adder, one with a combinational adder.
module tb_serial_add_seq;

    localparam int W = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] in_a = '0, in_b = '0;
    logic         in_cin = 1'b0, out_ready = 1'b0;
    logic         in_valid1 = 1'b0, in_valid0 = 1'b0;
    logic         sel1 = 1'b1;

    logic         in_ready1, fa_a1, fa_b1, fa_cin1, fa_issue1, fa_sum1, fa_cout1;
    logic         out_valid1, out_cout1, out_ovf1;
    logic [W-1:0] out_sum1;
    logic         in_ready0, fa_a0, fa_b0, fa_cin0, fa_issue0, fa_sum0, fa_cout0;
    logic         out_valid0, out_cout0, out_ovf0;
    logic [W-1:0] out_sum0;

    serial_add_seq #(.W(W), .FA_LAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_issue(fa_issue1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
    );

    serial_add_seq #(.W(W), .FA_LAT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .fa_a(fa_a0), .fa_b(fa_b0), .fa_cin(fa_cin0), .fa_issue(fa_issue0),
        .fa_sum(fa_sum0), .fa_cout(fa_cout0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_cout(out_cout0), .out_ovf(out_ovf0)
    );

    // Full adders attached to the two sequencers: registered (latency 1) and combinational.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {fa_cout1, fa_sum1} <= 2'b00;
        else       {fa_cout1, fa_sum1} <= {1'b0, fa_a1} + {1'b0, fa_b1} + {1'b0, fa_cin1};
    end
    assign {fa_cout0, fa_sum0} = {1'b0, fa_a0} + {1'b0, fa_b0} + {1'b0, fa_cin0};

    // Issue monitor for the latency-1 instance: count and the carry presented per issue.
    int           issue_cnt1 = 0;
    logic [W-1:0] cin_log1 = '0;
    always @(posedge clk) begin
        if (fa_issue1) begin
            issue_cnt1 <= issue_cnt1 + 1;
            cin_log1   <= {fa_cin1, cin_log1[W-1:1]};
        end
    end

    logic         rdy_s, vld_s, cout_s, ovf_s;
    logic [W-1:0] sum_s;
    assign rdy_s  = sel1 ? in_ready1  : in_ready0;
    assign vld_s  = sel1 ? out_valid1 : out_valid0;
    assign sum_s  = sel1 ? out_sum1   : out_sum0;
    assign cout_s = sel1 ? out_cout1  : out_cout0;
    assign ovf_s  = sel1 ? out_ovf1   : out_ovf0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: {cout, ovf, sum} from whole-word arithmetic.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, b, input logic c);
        int full, low, cmsb;
        full = int'(a) + int'(b) + int'(c);
        low  = (int'(a) % (1 << (W-1))) + (int'(b) % (1 << (W-1))) + int'(c);
        cmsb = low >> (W-1);
        return {1'(full >> W), 1'((full >> W) ^ cmsb), W'(full)};
    endfunction

    // Carry into bit k is the carry out of the k low bits added together.
    function automatic logic [W-1:0] ref_carries(input logic [W-1:0] a, b, input logic c);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            r[k] = 1'(((int'(a) % (1 << k)) + (int'(b) % (1 << k)) + int'(c)) >> k);
        end
        return r;
    endfunction

    task automatic accept(input logic [W-1:0] a, b, input logic c, output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!rdy_s && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rdy_s) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_a = a; in_b = b; in_cin = c;
        if (sel1) in_valid1 = 1'b1;
        else      in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!vld_s && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!vld_s) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake(input int dly);
        repeat (dly) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic c, input int dly,
                          output logic [W-1:0] s, output logic co, ov, output int lat);
        bit ok;
        s = '0; co = 1'b0; ov = 1'b0; lat = -1;
        accept(a, b, c, ok);
        if (!ok) return;
        wait_out(lat);
        s = sum_s; co = cout_s; ov = ovf_s;
        handshake(dly);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] s, ra, rb;
        logic         co, ov, rc;
        logic [W+1:0] exp;
        int           lat, ic0, k, spurious;

        tbl[0] = '{a: 4'd5,  b: 4'd6, cin: 1'b0, sum: 4'd11, cout: 1'b0, ovf: 1'b1};
        tbl[1] = '{a: 4'd15, b: 4'd1, cin: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 4'd7,  b: 4'd0, cin: 1'b1, sum: 4'd8,  cout: 1'b0, ovf: 1'b1};
        tbl[3] = '{a: 4'd8,  b: 4'd8, cin: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b1};
        tbl[4] = '{a: 4'd0,  b: 4'd0, cin: 1'b0, sum: 4'd0,  cout: 1'b0, ovf: 1'b0};
        tbl[5] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'd15, cout: 1'b1, ovf: 1'b0};

        #1 rstn = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready1), 32'd0);
        check("rst_out_valid", 32'(out_valid1), 32'd0);
        check("rst_out_sum",   32'(out_sum1), 32'd0);
        check("rst_fa_issue",  32'(fa_issue1), 32'd0);
        check("rst_fa_cin",    32'(fa_cin1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("in_ready_before_edge", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1 check("in_ready_after_edge", 32'(in_ready1), 32'd1);

        // Table vectors on the latency-1 instance, including per-issue carry sequence.
        for (int i = 0; i < 6; i++) begin
            ic0 = issue_cnt1;
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, i % 3, s, co, ov, lat);
            check($sformatf("tbl%0d_sum", i),  32'(s),  32'(tbl[i].sum));
            check($sformatf("tbl%0d_cout", i), 32'(co), 32'(tbl[i].cout));
            check($sformatf("tbl%0d_ovf", i),  32'(ov), 32'(tbl[i].ovf));
            check($sformatf("tbl%0d_lat", i),  32'(lat), 32'd8);
            check($sformatf("tbl%0d_issues", i), 32'(issue_cnt1 - ic0), 32'd4);
            check($sformatf("tbl%0d_cin_seq", i), 32'(cin_log1),
                  32'(ref_carries(tbl[i].a, tbl[i].b, tbl[i].cin)));
        end

        // New operands offered while busy must be ignored.
        begin
            bit ok;
            ic0 = issue_cnt1;
            accept(4'd7, 4'd0, 1'b1, ok);
            in_a = 4'd3; in_b = 4'd3; in_cin = 1'b0; in_valid1 = 1'b1;
            wait_out(lat);
            in_valid1 = 1'b0;
            check("busy_sum", 32'(out_sum1), 32'd8);
            check("busy_ovf", 32'(out_ovf1), 32'd1);
            check("busy_lat", 32'(lat), 32'd8);
            handshake(0);
            repeat (10) @(negedge clk);
            check("busy_no_extra_op", 32'(issue_cnt1 - ic0), 32'd4);
            check("busy_idle_ready", 32'(in_ready1), 32'd1);
        end

        // Backpressure: result and in_ready hold while out_ready stays low.
        begin
            bit ok;
            accept(4'd10, 4'd3, 1'b1, ok);
            wait_out(lat);
            k = 0;
            repeat (5) begin
                @(negedge clk);
                if (out_valid1 !== 1'b1 || out_sum1 !== 4'd14 || out_cout1 !== 1'b0 ||
                    out_ovf1 !== 1'b0 || in_ready1 !== 1'b0) k++;
            end
            check("bp_hold_errors", 32'(k), 32'd0);
            handshake(0);
            check("bp_in_ready_after", 32'(in_ready1), 32'd1);
            check("bp_out_valid_after", 32'(out_valid1), 32'd0);
            check("bp_sum_kept", 32'(out_sum1), 32'd14);
        end

        // Reset after three issues discards the operation.
        begin
            bit ok;
            ic0 = issue_cnt1;
            accept(4'd12, 4'd5, 1'b1, ok);
            k = 0;
            while (issue_cnt1 - ic0 < 3 && k < 40) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("rst_mid_reached_3", 32'(issue_cnt1 - ic0), 32'd3);
            @(negedge clk);
            rstn = 1'b0;
            #1;
            check("rst_mid_out_valid", 32'(out_valid1), 32'd0);
            check("rst_mid_in_ready",  32'(in_ready1), 32'd0);
            check("rst_mid_fa_issue",  32'(fa_issue1), 32'd0);
            check("rst_mid_out_sum",   32'(out_sum1), 32'd0);
            spurious = 0;
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (out_valid1) spurious++;
            end
            check("rst_mid_no_spurious", 32'(spurious), 32'd0);
            run_op(4'd3, 4'd3, 1'b0, 0, s, co, ov, lat);
            check("rst_after_sum", 32'(s), 32'd6);
            check("rst_after_lat", 32'(lat), 32'd8);
        end

        // Random operations on the latency-1 instance.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, $urandom_range(0, 3), s, co, ov, lat);
            check($sformatf("rnd1_%0d_res", i), 32'({co, ov, s}), 32'(exp));
            check($sformatf("rnd1_%0d_lat", i), 32'(lat), 32'd8);
            check($sformatf("rnd1_%0d_cin_seq", i), 32'(cin_log1), 32'(ref_carries(ra, rb, rc)));
        end

        // Combinational adder instance.
        sel1 = 1'b0;
        run_op(4'd9, 4'd9, 1'b1, 1, s, co, ov, lat);
        check("lat0_sum",  32'(s),  32'd3);
        check("lat0_cout", 32'(co), 32'd1);
        check("lat0_ovf",  32'(ov), 32'd1);
        check("lat0_lat",  32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = ref_add(ra, rb, rc);
            run_op(ra, rb, rc, $urandom_range(0, 2), s, co, ov, lat);
            check($sformatf("rnd0_%0d_res", i), 32'({co, ov, s}), 32'(exp));
            check($sformatf("rnd0_%0d_lat", i), 32'(lat), 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
